// File: rtl/map_blitter.sv
// map_blitter: streams a TILE_W x TILE_H tile from ROM to the VGA pixel port with screen clipping; `define TRANSPARENCY_EN to skip KEY_RGB pixels.
module map_blitter #(
    parameter int          TILE_W      = 16,
    parameter int          TILE_H      = 16,
    parameter int          ROM_LATENCY = 2,
    parameter int          SCREEN_W    = 160,
    parameter int          SCREEN_H    = 120,
    parameter logic [23:0] KEY_RGB     = 24'hFF00FF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        draw,
    input  logic [15:0] tile_address,
    input  logic [7:0]  x_origin,
    input  logic [7:0]  y_origin,
    input  logic [23:0] rom_request_data,
    output logic [15:0] rom_address_bus,
    output logic        vga_draw_enable_bus,
    output logic [7:0]  vga_x_out_bus,
    output logic [7:0]  vga_y_out_bus,
    output logic [23:0] vga_RGB_out_bus,
    output logic        active,
    output logic        done
);
    localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, STREAM = 3'd2, DRAIN = 3'd3, DONE = 3'd4;
`ifdef TRANSPARENCY_EN
    localparam logic TRANSP = 1'b1;
`else
    localparam logic TRANSP = 1'b0;
`endif
    logic [2:0]             state_q, state_d;
    logic [15:0]            addr_q;
    logic [7:0]             x0_q, y0_q, col_q, row_q, ox_q, oy_q;
    logic [3:0]             drain_q;
    logic [ROM_LATENCY-1:0] v_q;
    logic [8:0]             px_q [ROM_LATENCY];
    logic [8:0]             py_q [ROM_LATENCY];
    logic [23:0]            rgb_q;
    logic                   en_q, streaming, last_col, last_pix, visible, key;

    assign streaming = state_q == STREAM;
    assign last_col  = col_q == 8'(TILE_W - 1);
    assign last_pix  = last_col && row_q == 8'(TILE_H - 1);
    assign visible   = px_q[ROM_LATENCY-1] < 9'(SCREEN_W) && py_q[ROM_LATENCY-1] < 9'(SCREEN_H);
    assign key       = TRANSP && rom_request_data == KEY_RGB;

    always_comb begin
        state_d = state_q == IDLE   ? (draw ? LOAD : IDLE) :
                  state_q == LOAD   ? STREAM :
                  state_q == STREAM ? (last_pix ? DRAIN : STREAM) :
                  state_q == DRAIN  ? (drain_q == 4'(ROM_LATENCY) ? DONE : DRAIN) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            x0_q    <= '0;
            y0_q    <= '0;
            col_q   <= '0;
            row_q   <= '0;
            drain_q <= '0;
            v_q     <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == LOAD) begin
                addr_q  <= tile_address;
                x0_q    <= x_origin;
                y0_q    <= y_origin;
                col_q   <= '0;
                row_q   <= '0;
                drain_q <= '0;
            end
            // address freezes on the last pixel so DRAIN keeps showing it
            if (streaming && !last_pix) begin
                addr_q <= addr_q + 16'd1;
                col_q  <= last_col ? 8'd0 : col_q + 8'd1;
                row_q  <= last_col ? row_q + 8'd1 : row_q;
            end
            if (state_q == DRAIN) drain_q <= drain_q + 4'd1;
            v_q[0] <= streaming;
            for (int k = 1; k < ROM_LATENCY; k++) v_q[k] <= v_q[k-1];
            en_q <= v_q[ROM_LATENCY-1] && visible && !key;
        end
    end

    always_ff @(posedge clk) begin
        px_q[0] <= {1'b0, x0_q} + {1'b0, col_q};
        py_q[0] <= {1'b0, y0_q} + {1'b0, row_q};
        for (int k = 1; k < ROM_LATENCY; k++) begin
            px_q[k] <= px_q[k-1];
            py_q[k] <= py_q[k-1];
        end
        ox_q  <= px_q[ROM_LATENCY-1][7:0];
        oy_q  <= py_q[ROM_LATENCY-1][7:0];
        rgb_q <= rom_request_data;
    end

    assign active              = state_q != IDLE;
    assign done                = state_q == DONE;
    assign rom_address_bus     = active ? addr_q : 16'bz;
    assign vga_draw_enable_bus = active ? en_q : 1'bz;
    assign vga_x_out_bus       = active ? ox_q : 8'bz;
    assign vga_y_out_bus       = active ? oy_q : 8'bz;
    assign vga_RGB_out_bus     = active ? rgb_q : 24'bz;
endmodule

// File: tb/tb_map_blitter.sv
// tb_map_blitter: scoreboard bench driving a ROM_LATENCY=2 and a ROM_LATENCY=1 blitter in parallel from one stimulus stream.
module tb_map_blitter;
    typedef struct {
        bit          is_done;
        int          cyc;
        logic [7:0]  x, y;
        logic [23:0] rgb;
    } exp_t;

`ifdef TRANSPARENCY_EN
    localparam bit TR = 1'b1;
`else
    localparam bit TR = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b1, draw = 1'b0;
    logic [15:0] tile_address = '0, key_addr = 16'hFFFF;
    logic [7:0]  x_origin = '0, y_origin = '0;
    logic [15:0] ab0, ab1, ap0 [2], ap1;
    logic [23:0] rd0, rd1, rgb0, rgb1;
    logic [7:0]  x0, y0, x1, y1;
    logic        en0, en1, act0, act1, dn0, dn1;
    int          cyc = 0, tests = 0, fails = 0, t;
    exp_t        q0[$], q1[$];

    map_blitter #(.TILE_W(4), .TILE_H(2), .ROM_LATENCY(2)) dut0 (
        .clk(clk), .reset(reset), .draw(draw), .tile_address(tile_address),
        .x_origin(x_origin), .y_origin(y_origin), .rom_request_data(rd0),
        .rom_address_bus(ab0), .vga_draw_enable_bus(en0), .vga_x_out_bus(x0),
        .vga_y_out_bus(y0), .vga_RGB_out_bus(rgb0), .active(act0), .done(dn0));

    map_blitter #(.TILE_W(4), .TILE_H(2), .ROM_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .draw(draw), .tile_address(tile_address),
        .x_origin(x_origin), .y_origin(y_origin), .rom_request_data(rd1),
        .rom_address_bus(ab1), .vga_draw_enable_bus(en1), .vga_x_out_bus(x1),
        .vga_y_out_bus(y1), .vga_RGB_out_bus(rgb1), .active(act1), .done(dn1));

    always #5 clk = ~clk;

    function automatic logic [23:0] rom(input logic [15:0] a);
        return (a == key_addr) ? 24'hFF00FF : {8'h00, a};
    endfunction

    assign rd0 = rom(ap0[1]);
    assign rd1 = rom(ap1);

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        ap0[0] <= ab0;
        ap0[1] <= ap0[0];
        ap1    <= ab1;
    end

    // Pixel i of a tile whose draw was sampled at the end of cycle t appears at t+3+i+L; done at t+11+L.
    task automatic push_tile(input int lat, input int t0, input logic [7:0] xo, yo,
                             input logic [15:0] base, input int cut);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            int px = int'(xo) + i % 4, py = int'(yo) + i / 4;
            logic [15:0] a = base + 16'(i);
            e.is_done = 1'b0;
            e.cyc = t0 + 3 + i + lat;
            e.x = 8'(px);
            e.y = 8'(py);
            e.rgb = (a == key_addr) ? 24'hFF00FF : {8'h00, a};
            if (px < 160 && py < 120 && !(TR && a == key_addr) && (cut < 0 || e.cyc <= cut))
                if (lat == 2) q0.push_back(e); else q1.push_back(e);
        end
        if (cut < 0) begin
            e.is_done = 1'b1;
            e.cyc = t0 + 11 + lat;
            if (lat == 2) q0.push_back(e); else q1.push_back(e);
        end
    endtask

    task automatic issue(input logic [7:0] xo, yo, input logic [15:0] base, input int cut_off);
        @(posedge clk); #1;
        tile_address = base;
        x_origin = xo;
        y_origin = yo;
        draw = 1'b1;
        t = cyc;
        push_tile(2, t, xo, yo, base, cut_off < 0 ? -1 : t + cut_off);
        push_tile(1, t, xo, yo, base, cut_off < 0 ? -1 : t + cut_off);
        @(posedge clk); #1;
        draw = 1'b0;
    endtask

    task automatic mon(input int d, input logic en, dn, input logic [7:0] x, y, input logic [23:0] rgb);
        exp_t e;
        bit ok;
        if (en !== 1'b1 && dn !== 1'b1) return;
        tests++;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            fails++;
            $display("FAIL dut%0d unexpected event: en=%b done=%b x=%0d y=%0d rgb=%h cycle=%0d, none required",
                     d, en, dn, x, y, rgb, cyc);
            return;
        end
        if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
        ok = e.is_done ? (dn === 1'b1 && en !== 1'b1 && cyc == e.cyc)
                       : (en === 1'b1 && dn !== 1'b1 && cyc == e.cyc && x === e.x && y === e.y && rgb === e.rgb);
        if (!ok) begin
            fails++;
            $display("FAIL dut%0d event: got en=%b done=%b x=%0d y=%0d rgb=%h cycle=%0d, required done=%b x=%0d y=%0d rgb=%h cycle=%0d",
                     d, en, dn, x, y, rgb, cyc, e.is_done, e.x, e.y, e.rgb, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        mon(0, en0, dn0, x0, y0, rgb0);
        mon(1, en1, dn1, x1, y1, rgb1);
    end

    task automatic wait_idle(input string name);
        for (int k = 0; k < 100 && !(act0 === 1'b0 && act1 === 1'b0); k++) begin
            @(posedge clk); #1;
        end
        tests++;
        if (!(act0 === 1'b0 && act1 === 1'b0)) begin
            fails++;
            $display("FAIL %s idle timeout: active=%b/%b, required 0/0", name, act0, act1);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string name);
        tests++;
        if (act0 !== 1'b0 || act1 !== 1'b0 || dn0 !== 1'b0 || dn1 !== 1'b0 ||
            en0 === 1'b1 || en1 === 1'b1) begin
            fails++;
            $display("FAIL %s: active=%b/%b done=%b/%b draw_en=%b/%b, required active 0, done 0, bus released",
                     name, act0, act1, dn0, dn1, en0, en1);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_quiet("reset_state");
        issue(8'd10, 8'd20, 16'h0100, -1);
        wait_idle("basic");
        issue(8'd158, 8'd119, 16'h0200, -1);
        wait_idle("clip_corner");
        issue(8'd254, 8'd118, 16'h0300, -1);
        wait_idle("clip_no_wrap");
        key_addr = 16'h0103;
        issue(8'd10, 8'd20, 16'h0100, -1);
        wait_idle("key_colour");
        key_addr = 16'hFFFF;
        issue(8'd10, 8'd20, 16'h0400, -1);
        repeat (4) @(posedge clk);
        #1;
        draw = 1'b1;
        @(posedge clk); #1;
        draw = 1'b0;
        wait_idle("draw_in_stream");
        issue(8'd10, 8'd20, 16'h0500, 4);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_quiet("reset_mid_tile");
        repeat (20) @(posedge clk);
        #1;
        check_quiet("after_reset");
        issue(8'd0, 8'd0, 16'h0600, -1);
        wait_idle("post_reset_tile");
        tests++;
        if (q0.size() != 0 || q1.size() != 0) begin
            fails++;
            $display("FAIL leftover events: got %0d/%0d unseen, required 0/0", q0.size(), q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
